// File: rtl/cstuff_responder_if.sv
// cstuff_responder_if: bundles the cStuffIf request link (rdy_vld, responder
// is the destination) and the dStuffIf response link (rdy_vld, responder is
// the source). The slave modport is the responder's view; master is the peer.
interface cstuff_responder_if;
    logic       cStuffIf_vld;
    logic [4:0] cStuffIf_data;
    logic       cStuffIf_rdy;
    logic       dStuffIf_vld;
    logic [6:0] dStuffIf_data;
    logic       dStuffIf_rdy;

    modport slave (
        input  cStuffIf_vld,
        input  cStuffIf_data,
        output cStuffIf_rdy,
        output dStuffIf_vld,
        output dStuffIf_data,
        input  dStuffIf_rdy
    );

    modport master (
        output cStuffIf_vld,
        output cStuffIf_data,
        input  cStuffIf_rdy,
        input  dStuffIf_vld,
        input  dStuffIf_data,
        output dStuffIf_rdy
    );
endinterface

// File: rtl/cstuff_responder.sv
// cstuff_responder: cStuff peer model. Queues 5-bit seeSt requests in a
// DEPTH-entry FIFO and returns 7-bit dSt responses {seq[1:0], req[4:0]} from a
// single output register, paced by an IDLE/SEND/GAP FSM. rwD_data publishes
// the last response that completed a handshake.
// Optional feature: define CSTUFF_RSP_STATS_EN to add the saturating 16-bit
// rsp_cnt output counting response handshakes.
module cstuff_responder #(
    parameter int DEPTH   = 4,
    parameter int RSP_GAP = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    cstuff_responder_if.slave        bus,
    output logic [6:0]               rwD_data,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef CSTUFF_RSP_STATS_EN
    ,
    output logic [15:0]              rsp_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [4:0]    fifoMem [DEPTH];
    logic [PW-1:0] wrPtr_q, rdPtr_q;
    logic [LW-1:0] level_q, level_d;
    state_t        state_q, state_d;
    logic          outVld_q, outVld_d;
    logic [6:0]    outData_q, outData_d;
    logic [1:0]    seq_q, seq_d;
    logic [3:0]    gapCnt_q, gapCnt_d;
    logic [6:0]    rwD_q, rwD_d;
    logic          fifoFull, fifoEmpty, push, pop, handshake;
    logic [4:0]    headData;

    // Ready comes from the stored level only: a pop in the same cycle does not
    // open a slot for a push, which keeps ready free of any output-side path.
    assign fifoFull         = (level_q == LW'(DEPTH));
    assign fifoEmpty        = (level_q == '0);
    assign bus.cStuffIf_rdy = !rst && !fifoFull;
    assign push             = bus.cStuffIf_vld && bus.cStuffIf_rdy;
    assign handshake        = outVld_q && bus.dStuffIf_rdy;
    assign headData         = fifoMem[rdPtr_q];

    assign bus.dStuffIf_vld  = outVld_q;
    assign bus.dStuffIf_data = outData_q;
    assign rwD_data          = rwD_q;
    assign fifo_level        = level_q;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr_q] <= bus.cStuffIf_data;
        end
    end

    // Level follows push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO pointers and level; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
            level_q <= level_d;
        end
    end

    // Response pacing: load the output register from the FIFO head, hold it
    // until the handshake, then either stream, fall idle, or insert a gap.
    always_comb begin
        state_d   = state_q;
        outVld_d  = outVld_q;
        outData_d = outData_q;
        seq_d     = seq_q;
        gapCnt_d  = gapCnt_q;
        rwD_d     = rwD_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    outVld_d  = 1'b1;
                    outData_d = {seq_q, headData};
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    rwD_d = outData_q;
                    seq_d = seq_q + 2'd1;
                    if (RSP_GAP == 0) begin
                        if (!fifoEmpty) begin
                            pop       = 1'b1;
                            outData_d = {seq_q + 2'd1, headData};
                        end else begin
                            outVld_d = 1'b0;
                            state_d  = IDLE;
                        end
                    end else begin
                        outVld_d = 1'b0;
                        gapCnt_d = 4'(RSP_GAP);
                        state_d  = GAP;
                    end
                end
            end
            GAP: begin
                if (gapCnt_q == 4'd1) begin
                    gapCnt_d = 4'd0;
                    if (!fifoEmpty) begin
                        pop       = 1'b1;
                        outVld_d  = 1'b1;
                        outData_d = {seq_q, headData};
                        state_d   = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gapCnt_d = gapCnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and output register state; reset drops any in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            outVld_q  <= 1'b0;
            outData_q <= '0;
            seq_q     <= '0;
            gapCnt_q  <= '0;
            rwD_q     <= '0;
        end else begin
            state_q   <= state_d;
            outVld_q  <= outVld_d;
            outData_q <= outData_d;
            seq_q     <= seq_d;
            gapCnt_q  <= gapCnt_d;
            rwD_q     <= rwD_d;
        end
    end

`ifdef CSTUFF_RSP_STATS_EN
    logic [15:0] rspCnt_q;

    // Saturating count of response handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rspCnt_q <= '0;
        end else if (handshake && (rspCnt_q != 16'hFFFF)) begin
            rspCnt_q <= rspCnt_q + 16'd1;
        end
    end

    assign rsp_cnt = rspCnt_q;
`endif

endmodule

// File: tb/tb_cstuff_responder.sv
// tb_cstuff_responder: directed bench for cstuff_responder. A vector table
// drives one cycle per entry on a DEPTH=4 / RSP_GAP=0 instance; hand-written
// sequences cover long backpressure, RSP_GAP=3 pacing on a second instance,
// and (with CSTUFF_RSP_STATS_EN) counter saturation.
module tb_cstuff_responder;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [4:0] data;
        logic       dRdy;
        logic       expCRdy;
        logic       expDVld;
        logic [6:0] expDData;
        logic [2:0] expLevel;
        logic [6:0] expRwD;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecCount  = 0;
    int   missCount = 0;
    vec_t vecs[$];

    cstuff_responder_if bus0 ();
    cstuff_responder_if bus3 ();
    logic [6:0] rwD0, rwD3;
    logic [2:0] lvl0, lvl3;
`ifdef CSTUFF_RSP_STATS_EN
    logic [15:0] cnt0, cnt3;
`endif

    cstuff_responder #(.DEPTH(4), .RSP_GAP(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave),
        .rwD_data(rwD0), .fifo_level(lvl0)
`ifdef CSTUFF_RSP_STATS_EN
        , .rsp_cnt(cnt0)
`endif
    );

    cstuff_responder #(.DEPTH(4), .RSP_GAP(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave),
        .rwD_data(rwD3), .fifo_level(lvl3)
`ifdef CSTUFF_RSP_STATS_EN
        , .rsp_cnt(cnt3)
`endif
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic v, input logic [4:0] d, input logic dr,
                          input logic cr, input logic dv, input logic [6:0] dd,
                          input logic [2:0] lv, input logic [6:0] rw);
        vec_t e;
        e.rst = r; e.vld = v; e.data = d; e.dRdy = dr;
        e.expCRdy = cr; e.expDVld = dv; e.expDData = dd; e.expLevel = lv; e.expRwD = rw;
        vecs.push_back(e);
    endtask

    // Drive one vector at the falling edge, then check just after.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        rst               = v.rst;
        bus0.cStuffIf_vld  = v.vld;
        bus0.cStuffIf_data = v.data;
        bus0.dStuffIf_rdy  = v.dRdy;
        #1;
        checkOutput($sformatf("v%0d cRdy", idx),  32'(bus0.cStuffIf_rdy),  32'(v.expCRdy));
        checkOutput($sformatf("v%0d dVld", idx),  32'(bus0.dStuffIf_vld),  32'(v.expDVld));
        checkOutput($sformatf("v%0d dData", idx), 32'(bus0.dStuffIf_data), 32'(v.expDData));
        checkOutput($sformatf("v%0d level", idx), 32'(lvl0),               32'(v.expLevel));
        checkOutput($sformatf("v%0d rwD", idx),   32'(rwD0),               32'(v.expRwD));
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        bus0.cStuffIf_vld = 1'b0; bus0.cStuffIf_data = '0; bus0.dStuffIf_rdy = 1'b0;
        bus3.cStuffIf_vld = 1'b0; bus3.cStuffIf_data = '0; bus3.dStuffIf_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int hsCount;
        int lowRun;
        logic [6:0] gapExp [4];

        bus0.cStuffIf_vld = 1'b0; bus0.cStuffIf_data = '0; bus0.dStuffIf_rdy = 1'b0;
        bus3.cStuffIf_vld = 1'b0; bus3.cStuffIf_data = '0; bus3.dStuffIf_rdy = 1'b0;

        // rst vld data dRdy | cRdy dVld dData level rwD
        // Reset with three entries queued and the output register stalled.
        addVec(0, 1, 5'h11, 0,  1, 0, 7'h00, 3'd0, 7'h00);
        addVec(0, 1, 5'h12, 0,  1, 0, 7'h00, 3'd1, 7'h00);
        addVec(0, 1, 5'h13, 0,  1, 1, 7'h11, 3'd1, 7'h00);
        addVec(0, 1, 5'h14, 0,  1, 1, 7'h11, 3'd2, 7'h00);
        addVec(1, 0, 5'h00, 0,  0, 0, 7'h00, 3'd0, 7'h00);
        addVec(0, 0, 5'h00, 0,  1, 0, 7'h00, 3'd0, 7'h00);
        // Single request 0A.
        addVec(0, 1, 5'h0A, 1,  1, 0, 7'h00, 3'd0, 7'h00);
        addVec(0, 0, 5'h00, 1,  1, 0, 7'h00, 3'd1, 7'h00);
        addVec(0, 0, 5'h00, 1,  1, 1, 7'h0A, 3'd0, 7'h00);
        addVec(0, 0, 5'h00, 1,  1, 0, 7'h0A, 3'd0, 7'h0A);
        addVec(1, 0, 5'h00, 1,  0, 0, 7'h00, 3'd0, 7'h00);
        // Streaming 01..05, seq wraps.
        addVec(0, 1, 5'h01, 1,  1, 0, 7'h00, 3'd0, 7'h00);
        addVec(0, 1, 5'h02, 1,  1, 0, 7'h00, 3'd1, 7'h00);
        addVec(0, 1, 5'h03, 1,  1, 1, 7'h01, 3'd1, 7'h00);
        addVec(0, 1, 5'h04, 1,  1, 1, 7'h22, 3'd1, 7'h01);
        addVec(0, 1, 5'h05, 1,  1, 1, 7'h43, 3'd1, 7'h22);
        addVec(0, 0, 5'h00, 1,  1, 1, 7'h64, 3'd1, 7'h43);
        addVec(0, 0, 5'h00, 1,  1, 1, 7'h05, 3'd0, 7'h64);
        addVec(0, 0, 5'h00, 1,  1, 0, 7'h05, 3'd0, 7'h05);
        addVec(1, 0, 5'h00, 1,  0, 0, 7'h00, 3'd0, 7'h00);
        // Fill to full, no pop pass-through, then drain in order.
        addVec(0, 1, 5'h01, 0,  1, 0, 7'h00, 3'd0, 7'h00);
        addVec(0, 1, 5'h02, 0,  1, 0, 7'h00, 3'd1, 7'h00);
        addVec(0, 1, 5'h03, 0,  1, 1, 7'h01, 3'd1, 7'h00);
        addVec(0, 1, 5'h04, 0,  1, 1, 7'h01, 3'd2, 7'h00);
        addVec(0, 1, 5'h05, 0,  1, 1, 7'h01, 3'd3, 7'h00);
        addVec(0, 1, 5'h06, 0,  0, 1, 7'h01, 3'd4, 7'h00);
        addVec(0, 1, 5'h06, 1,  0, 1, 7'h01, 3'd4, 7'h00);
        addVec(0, 1, 5'h06, 0,  1, 1, 7'h22, 3'd3, 7'h01);
        addVec(0, 0, 5'h00, 1,  0, 1, 7'h22, 3'd4, 7'h01);
        addVec(0, 0, 5'h00, 1,  1, 1, 7'h43, 3'd3, 7'h22);
        addVec(0, 0, 5'h00, 1,  1, 1, 7'h64, 3'd2, 7'h43);
        addVec(0, 0, 5'h00, 1,  1, 1, 7'h05, 3'd1, 7'h64);
        addVec(0, 0, 5'h00, 1,  1, 1, 7'h26, 3'd0, 7'h05);
        addVec(0, 0, 5'h00, 1,  1, 0, 7'h26, 3'd0, 7'h26);
        addVec(1, 0, 5'h00, 0,  0, 0, 7'h00, 3'd0, 7'h00);

        // Initial reset release.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Long backpressure: response must hold for 10 stalled cycles.
        resetDut();
        bus0.cStuffIf_vld = 1'b1; bus0.cStuffIf_data = 5'h15; bus0.dStuffIf_rdy = 1'b0;
        @(negedge clk);
        bus0.cStuffIf_vld = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput($sformatf("stall%0d vld", i),  32'(bus0.dStuffIf_vld),  32'd1);
            checkOutput($sformatf("stall%0d data", i), 32'(bus0.dStuffIf_data), 32'h15);
            checkOutput($sformatf("stall%0d rwD", i),  32'(rwD0),               32'h00);
            @(negedge clk);
        end
        bus0.dStuffIf_rdy = 1'b1;
        @(negedge clk);
        bus0.dStuffIf_rdy = 1'b0;
        #1;
        checkOutput("stall release rwD", 32'(rwD0),              32'h15);
        checkOutput("stall release vld", 32'(bus0.dStuffIf_vld), 32'd0);

        // RSP_GAP=3 with backlog: 3 vld-low cycles between every handshake.
        resetDut();
        gapExp[0] = 7'h01; gapExp[1] = 7'h22; gapExp[2] = 7'h43; gapExp[3] = 7'h64;
        for (int i = 1; i <= 4; i++) begin
            bus3.cStuffIf_vld  = 1'b1;
            bus3.cStuffIf_data = 5'(i);
            @(negedge clk);
        end
        bus3.cStuffIf_vld = 1'b0;
        bus3.dStuffIf_rdy = 1'b1;
        hsCount = 0;
        lowRun  = 0;
        for (int cyc = 0; cyc < 40 && hsCount < 4; cyc++) begin
            #1;
            if (bus3.dStuffIf_vld) begin
                if (hsCount > 0) begin
                    checkOutput($sformatf("gap before hs%0d", hsCount), 32'(lowRun), 32'd3);
                end
                checkOutput($sformatf("gap hs%0d data", hsCount), 32'(bus3.dStuffIf_data), 32'(gapExp[hsCount]));
                hsCount++;
                lowRun = 0;
            end else if (hsCount > 0) begin
                lowRun++;
            end
            @(negedge clk);
        end
        checkOutput("gap handshake count", 32'(hsCount), 32'd4);
        #1;
        checkOutput("gap final rwD", 32'(rwD3), 32'h64);
        checkOutput("gap final vld", 32'(bus3.dStuffIf_vld), 32'd0);
        bus3.dStuffIf_rdy = 1'b0;

`ifdef CSTUFF_RSP_STATS_EN
        // Counter saturation after 70000+ handshakes, hold, then reset.
        resetDut();
        bus0.cStuffIf_vld = 1'b1; bus0.cStuffIf_data = 5'h07; bus0.dStuffIf_rdy = 1'b1;
        repeat (70010) @(negedge clk);
        #1;
        checkOutput("rsp_cnt saturated", 32'(cnt0), 32'hFFFF);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("rsp_cnt holds", 32'(cnt0), 32'hFFFF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rsp_cnt reset", 32'(cnt0), 32'h0000);
        bus0.cStuffIf_vld = 1'b0; bus0.dStuffIf_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
